bloom_word_hasher: RTL



---
 rtl/bloom_word_hasher.sv | 137 +++++++++++++
 1 files changed

// File: rtl/bloom_word_hasher.sv
// Splits an ASCII byte stream into words and emits two 8-bit hashes per word.
// Optional macro BLOOM_HASH_CASEFOLD_EN folds A-Z to lowercase before hashing.
module bloom_word_hasher #(
  parameter logic [7:0]  DELIM   = 8'h20,
  parameter int unsigned MAX_LEN = 32,
  parameter logic [7:0]  H1_SEED = 8'h00,
  parameter logic [7:0]  H2_SEED = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       char_valid,
  output logic       char_ready,
  input  logic [7:0] char_in,
  input  logic       char_last,
  input  logic       op_write,
  input  logic       hash_ready,
  output logic       hash_valid,
  output logic [7:0] hash1,
  output logic [7:0] hash2,
  output logic       write,
  output logic       check,
  output logic       word_trunc
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  state_t             state;
  logic [LEN_W-1:0]   len;
  logic               trunc;
  logic               op_q;

  logic [7:0]         fc;
  logic               accept;
  logic               is_delim;
  logic               at_limit;

  function automatic logic [7:0] fold(input logic [7:0] c);
`ifdef BLOOM_HASH_CASEFOLD_EN
    if (c >= 8'h41 && c <= 8'h5A) return c | 8'h20;
`endif
    return c;
  endfunction

  function automatic logic [7:0] rot_xor(input logic [7:0] a, input logic [7:0] c);
    return {a[4:0], a[7:5]} ^ c;
  endfunction

  // a*31 computed as a*32 - a, all in 8-bit wrap-around arithmetic
  function automatic logic [7:0] mul_add(input logic [7:0] a, input logic [7:0] c);
    return {a[2:0], 5'b00000} - a + c;
  endfunction

  always_comb begin
    fc       = fold(char_in);
    accept   = char_valid & char_ready;
    is_delim = (fc == DELIM);
    at_limit = (len == LEN_W'(MAX_LEN));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      len        <= '0;
      trunc      <= 1'b0;
      op_q       <= 1'b0;
      char_ready <= 1'b0;
      hash_valid <= 1'b0;
      hash1      <= H1_SEED;
      hash2      <= H2_SEED;
      write      <= 1'b0;
      check      <= 1'b0;
      word_trunc <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          char_ready <= 1'b1;
          if (accept && !is_delim) begin
            op_q  <= op_write;
            hash1 <= rot_xor(H1_SEED, fc);
            hash2 <= mul_add(H2_SEED, fc);
            len   <= LEN_W'(1);
            if (char_last) begin
              state      <= EMIT;
              char_ready <= 1'b0;
              hash_valid <= 1'b1;
              write      <= op_write;
              check      <= ~op_write;
              word_trunc <= 1'b0;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          char_ready <= 1'b1;
          if (accept) begin
            if (!is_delim) begin
              if (!at_limit) begin
                hash1 <= rot_xor(hash1, fc);
                hash2 <= mul_add(hash2, fc);
                len   <= len + LEN_W'(1);
              end else begin
                trunc <= 1'b1;
              end
            end
            if (is_delim || char_last) begin
              state      <= EMIT;
              char_ready <= 1'b0;
              hash_valid <= 1'b1;
              write      <= op_q;
              check      <= ~op_q;
              word_trunc <= trunc | (!is_delim && at_limit);
            end
          end
        end
        EMIT: begin
          if (hash_ready) begin
            state      <= IDLE;
            char_ready <= 1'b1;
            hash_valid <= 1'b0;
            write      <= 1'b0;
            check      <= 1'b0;
            word_trunc <= 1'b0;
            trunc      <= 1'b0;
            len        <= '0;
            hash1      <= H1_SEED;
            hash2      <= H2_SEED;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
